arm7tdmi_exception_sequencer: RTL and testbench

ARM7TDMI_EXCEPTION_SEQUENCER -- requirements
Module: arm7tdmi_exception_sequencer

---
 rtl/arm7tdmi_exception_sequencer.sv | 143 ++++++++++++++
 tb/tb_arm7tdmi_exception_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_exception_sequencer.sv
// ARM7TDMI exception entry sequencer: MODE -> SPSR -> LR -> VEC register-file writes.
// Optional entry counter enabled by defining EXC_SEQ_STATS_EN.
module arm7tdmi_exception_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        exc_req,
    input  logic [4:0]  exc_mode,
    input  logic [31:0] exc_vector,
    input  logic [31:0] exc_return_addr,
    input  logic [31:0] cpsr_in,
    output logic        exc_ack,
    output logic        exc_err,
    output logic        busy,
    output logic [31:0] rf_wdata,
    output logic        rf_mode_change,
    output logic        rf_cpsr_write,
    output logic        rf_spsr_write,
    output logic        rf_lr_write,
    output logic        rf_pc_write,
    output logic        pipeline_flush,
    output logic [31:0] exc_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MODE = 3'd1;
    localparam logic [2:0] ST_SPSR = 3'd2;
    localparam logic [2:0] ST_LR   = 3'd3;
    localparam logic [2:0] ST_VEC  = 3'd4;

    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    logic [2:0]  state_q, state_d;
    logic [4:0]  mode_q;
    logic [31:0] vec_q, ret_q, cpsr_q;
    logic        mode_valid;
    logic        idle;
    logic        req_seen;
    logic        accept;

    always_comb begin
        mode_valid = (exc_mode == MODE_FIQ) || (exc_mode == MODE_IRQ) ||
                     (exc_mode == MODE_SVC) || (exc_mode == MODE_ABT) ||
                     (exc_mode == MODE_UND);
    end

    assign idle     = (state_q == ST_IDLE);
    // Reset also masks the combinational handshake so every output reads 0 under rst.
    assign req_seen = exc_req & idle & ~hold & ~rst;
    assign accept   = req_seen & mode_valid;
    assign exc_ack  = accept;
    assign exc_err  = req_seen & ~mode_valid;
    assign busy     = ~idle;

    always_comb begin
        state_d = state_q;
        if (!hold) begin
            case (state_q)
                ST_IDLE: if (accept) state_d = ST_MODE;
                ST_MODE: state_d = ST_SPSR;
                ST_SPSR: state_d = ST_LR;
                ST_LR:   state_d = ST_VEC;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= '0;
            vec_q  <= '0;
            ret_q  <= '0;
            cpsr_q <= '0;
        end else if (accept) begin
            mode_q <= exc_mode;
            vec_q  <= exc_vector;
            ret_q  <= exc_return_addr;
            cpsr_q <= cpsr_in;
        end
    end

    // Data follows state even while frozen; only the strobes are gated by hold.
    always_comb begin
        rf_wdata       = '0;
        rf_mode_change = 1'b0;
        rf_cpsr_write  = 1'b0;
        rf_spsr_write  = 1'b0;
        rf_lr_write    = 1'b0;
        rf_pc_write    = 1'b0;
        pipeline_flush = 1'b0;
        case (state_q)
            ST_MODE: begin
                rf_wdata       = {cpsr_q[31:8], 1'b1, cpsr_q[6] | (mode_q == MODE_FIQ),
                                  1'b0, mode_q};
                rf_mode_change = ~hold;
                rf_cpsr_write  = ~hold;
            end
            ST_SPSR: begin
                rf_wdata      = cpsr_q;
                rf_spsr_write = ~hold;
            end
            ST_LR: begin
                rf_wdata    = ret_q;
                rf_lr_write = ~hold;
            end
            ST_VEC: begin
                rf_wdata       = vec_q;
                rf_pc_write    = ~hold;
                pipeline_flush = ~hold;
            end
            default: ;
        endcase
    end

`ifdef EXC_SEQ_STATS_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if ((state_q == ST_VEC) && !hold) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign exc_count = count_q;
`else
    assign exc_count = 32'h0;
`endif

endmodule

// File: tb/tb_arm7tdmi_exception_sequencer.sv
// Scoreboard bench: a write-list model predicts per-cycle control and the register-file writes.
module tb_arm7tdmi_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_mode = '0;
    logic [31:0] exc_vector = '0;
    logic [31:0] exc_return_addr = '0;
    logic [31:0] cpsr_in = '0;
    logic        exc_ack, exc_err, busy;
    logic [31:0] rf_wdata;
    logic        rf_mode_change, rf_cpsr_write, rf_spsr_write, rf_lr_write, rf_pc_write;
    logic        pipeline_flush;
    logic [31:0] exc_count;

    always #5 clk = ~clk;

    arm7tdmi_exception_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .hold            (hold),
        .exc_req         (exc_req),
        .exc_mode        (exc_mode),
        .exc_vector      (exc_vector),
        .exc_return_addr (exc_return_addr),
        .cpsr_in         (cpsr_in),
        .exc_ack         (exc_ack),
        .exc_err         (exc_err),
        .busy            (busy),
        .rf_wdata        (rf_wdata),
        .rf_mode_change  (rf_mode_change),
        .rf_cpsr_write   (rf_cpsr_write),
        .rf_spsr_write   (rf_spsr_write),
        .rf_lr_write     (rf_lr_write),
        .rf_pc_write     (rf_pc_write),
        .pipeline_flush  (pipeline_flush),
        .exc_count       (exc_count)
    );

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        busy;
        logic        stb;
        logic [31:0] wdata;
        logic [31:0] count;
    } ctl_t;

    // Strobe order: {mode_change, cpsr, spsr, lr, pc, flush}
    typedef struct packed {
        logic [5:0]  stb;
        logic [31:0] data;
    } wr_t;

    ctl_t        ctl_q[$];
    wr_t         wr_q[$];
    wr_t         pend[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_count = '0;
    logic        m_ack = 1'b0;
    logic        m_err = 1'b0;

    localparam logic [4:0] FIQ = 5'b10001;
    localparam logic [4:0] IRQ = 5'b10010;
    localparam logic [4:0] SVC = 5'b10011;
    localparam logic [4:0] ABT = 5'b10111;
    localparam logic [4:0] UND = 5'b11011;

    logic [4:0] modes [5] = '{FIQ, IRQ, SVC, ABT, UND};

    function automatic bit mode_ok(input logic [4:0] m);
        return (m == FIQ) || (m == IRQ) || (m == SVC) || (m == ABT) || (m == UND);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // An entry is four writes: new CPSR (I set, FIQ also sets F, Thumb cleared), SPSR, LR, PC.
    task automatic push_entry(input logic [4:0] m, input logic [31:0] v, input logic [31:0] ra,
                              input logic [31:0] c);
        logic [31:0] ncpsr;
        wr_t w;
        ncpsr      = c;
        ncpsr[4:0] = m;
        ncpsr[5]   = 1'b0;
        ncpsr[7]   = 1'b1;
        if (m == FIQ) ncpsr[6] = 1'b1;
        w = {6'b110000, ncpsr}; pend.push_back(w);
        w = {6'b001000, c};     pend.push_back(w);
        w = {6'b000100, ra};    pend.push_back(w);
        w = {6'b000011, v};     pend.push_back(w);
    endtask

    task automatic drive_cycle(input logic r, input logic h, input logic rq, input logic [4:0] m,
                               input logic [31:0] v, input logic [31:0] ra, input logic [31:0] c);
        ctl_t e;
        wr_t  w;
        bit   idle_m;
        @(posedge clk);
        #1;
        rst = r; hold = h; exc_req = rq; exc_mode = m;
        exc_vector = v; exc_return_addr = ra; cpsr_in = c;
        e = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
        if (r) begin
            pend.delete();
            m_count = '0;
        end else begin
            idle_m  = (pend.size() == 0);
            e.ack   = rq && idle_m && !h && mode_ok(m);
            e.err   = rq && idle_m && !h && !mode_ok(m);
            e.busy  = !idle_m;
            e.stb   = !idle_m && !h;
            e.count = m_count;
            if (!idle_m) e.wdata = pend[0].data;
            if (e.stb) begin
                w = pend.pop_front();
                wr_q.push_back(w);
`ifdef EXC_SEQ_STATS_EN
                if (w.stb[1]) m_count = m_count + 32'd1;
`endif
            end
            if (e.ack) push_entry(m, v, ra, c);
            m_ack = e.ack;
            m_err = e.err;
        end
        ctl_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive_cycle(0, 0, 0, 5'($urandom), $urandom, $urandom, $urandom);
    endtask

    ctl_t       mon_e;
    wr_t        mon_w;
    logic [5:0] mon_s;

    always @(negedge clk) begin
        if (ctl_q.size() != 0) begin
            mon_e = ctl_q.pop_front();
            mon_s = {rf_mode_change, rf_cpsr_write, rf_spsr_write, rf_lr_write, rf_pc_write,
                     pipeline_flush};
            check("exc_ack", 32'(exc_ack), 32'(mon_e.ack));
            check("exc_err", 32'(exc_err), 32'(mon_e.err));
            check("busy", 32'(busy), 32'(mon_e.busy));
            check("any_strobe", 32'(|mon_s), 32'(mon_e.stb));
            check("rf_wdata", rf_wdata, mon_e.wdata);
            check("exc_count", exc_count, mon_e.count);
            if (mon_s != 6'b0) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: strobes %b, none expected", mon_s);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("write_strobes", 32'(mon_s), 32'(mon_w.stb));
                    check("write_data", rf_wdata, mon_w.data);
                end
            end
        end
    end

    logic       rq_on;
    logic [4:0] rq_mode;
    logic [31:0] rq_v, rq_ra, rq_c;

    initial begin
        repeat (3) drive_cycle(1, 0, 1, IRQ, 32'h18, 32'h1004, 32'h6000001F);
        #1;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_ack", 32'(exc_ack), 32'h0);

        // IRQ in the very first cycle after reset, then junk on the inputs during the entry
        drive_cycle(0, 0, 1, IRQ, 32'h0000_0018, 32'h0000_1004, 32'h6000_001F);
        idle_cycles(5);

        drive_cycle(0, 0, 1, FIQ, 32'h0000_001C, 32'h0000_2000, 32'h0000_0010);
        idle_cycles(5);

        // Freeze for three cycles while sitting in LR
        drive_cycle(0, 0, 1, ABT, 32'h0000_0010, 32'h0000_3008, 32'hA000_0013);
        drive_cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        drive_cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (3) drive_cycle(0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        idle_cycles(4);

        // Back-to-back SVC with the request never dropped
        repeat (11) drive_cycle(0, 0, 1, SVC, 32'h0000_0008, 32'h0000_4004, 32'h0000_00D3);
        idle_cycles(5);

        // Reset landing on the SPSR cycle
        drive_cycle(0, 0, 1, UND, 32'h0000_0004, 32'h0000_5000, 32'h1000_0010);
        drive_cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        drive_cycle(1, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        check("rst_mid_wdata", rf_wdata, 32'h0);
        check("rst_mid_strobes", 32'({rf_cpsr_write, rf_spsr_write, rf_lr_write, rf_pc_write}),
              32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        idle_cycles(6);

        drive_cycle(0, 0, 1, 5'b10000, 32'h0, 32'h0, 32'h0);
        idle_cycles(2);

        rq_on = 1'b0;
        rq_mode = '0;
        rq_v = '0;
        rq_ra = '0;
        rq_c = '0;
        for (int i = 0; i < 800; i++) begin
            if (!rq_on && $urandom_range(0, 2) == 0) begin
                rq_on   = 1'b1;
                rq_mode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : modes[$urandom_range(0, 4)];
                rq_v    = $urandom;
                rq_ra   = $urandom;
                rq_c    = $urandom;
            end
            if ($urandom_range(0, 99) == 0) begin
                drive_cycle(1, 0, rq_on, rq_mode, rq_v, rq_ra, rq_c);
            end else if (rq_on) begin
                drive_cycle(0, $urandom_range(0, 4) == 0, 1, rq_mode, rq_v, rq_ra, rq_c);
            end else begin
                drive_cycle(0, $urandom_range(0, 4) == 0, 0, 5'($urandom), $urandom, $urandom,
                            $urandom);
            end
            if (m_ack || m_err) rq_on = 1'b0;
        end
        idle_cycles(8);

`ifdef EXC_SEQ_STATS_EN
        @(posedge clk);
        #1;
        force dut.count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        drive_cycle(0, 0, 1, IRQ, 32'h18, 32'h1004, 32'h6000001F);
        idle_cycles(5);
        check("count_wrap", exc_count, 32'h0);
`endif

        @(negedge clk);
        #1;
        check("writes_left", 32'(wr_q.size()), 32'h0);
        check("entries_left", 32'(pend.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
